// File: rtl/dsp_defs.sv
// Shared definitions for the DSP slice: operand/product widths and a saturating adder.
package dsp_defs;

  localparam int P_W       = 48;
  localparam int OPND_W    = 18;
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Unsigned add of two w-bit values (w <= SAT_MAX_W); clamps to all-ones on carry out of bit w-1.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                       input logic [SAT_MAX_W-1:0] b,
                                       input int                   w);
    logic [SAT_MAX_W:0]   full;
    logic [SAT_MAX_W-1:0] mask;
    sat_res_t             r;
    mask  = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
    full  = {1'b0, a} + {1'b0, b};
    r.ovf = |(full >> w);
    r.sum = r.ovf ? mask : (full[SAT_MAX_W-1:0] & mask);
    return r;
  endfunction

endpackage

// File: rtl/dsp_out_fifo2.sv
// Two-entry valid/ready output queue; the head register holds its last value once drained.
module dsp_out_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         full_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         head_vld_q, head_vld_d;
  logic         tail_vld_q, tail_vld_d;
  logic         pop;

  assign pop     = head_vld_q & ready_i;
  assign full_o  = head_vld_q & tail_vld_q;
  assign valid_o = head_vld_q;
  assign data_o  = head_q;

  // The caller must not push when full unless a pop happens in the same cycle.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (pop) begin
      head_vld_d = tail_vld_q;
      tail_vld_d = 1'b0;
      if (tail_vld_q) head_d = tail_q;
    end
    if (push_i) begin
      if (!head_vld_d) begin
        head_d     = push_data_i;
        head_vld_d = 1'b1;
      end else begin
        tail_d     = push_data_i;
        tail_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

endmodule

// File: rtl/dsp_p_accumulator.sv
// Sums ACC_LEN valid P products per frame with saturation; totals leave via a 2-entry queue,
// frames finishing into a full queue are dropped and counted.
module dsp_p_accumulator
  import dsp_defs::*;
#(
  parameter int ACC_LEN = 8,
  parameter int ACC_W   = 56,
  parameter int DROP_W  = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [P_W-1:0]    P_IN,
  input  logic              P_VALID,
  input  logic              CLEAR,
  output logic [ACC_W-1:0]  ACC_OUT,
  output logic              ACC_OVF,
  output logic              ACC_VALID,
  input  logic              ACC_READY,
  output logic [DROP_W-1:0] DROP_CNT,
  output logic              BUSY
);

  localparam int               CNT_W    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  sat_res_t          add_res;
  logic [ACC_W-1:0]  sum;
  logic              sum_ovf;
  logic              push_req;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_push;

  assign add_res = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(P_IN), ACC_W);
  assign sum_ovf = add_res.ovf | ovf_acc_q;
  assign sum     = ovf_acc_q ? {ACC_W{1'b1}} : add_res.sum[ACC_W-1:0];

  if (ACC_W < SAT_MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^add_res.sum[SAT_MAX_W-1:ACC_W];
  end

  // CLEAR outranks a coincident sample; the last sample of a frame restarts the accumulator
  // whether or not its total finds room in the queue.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    push_req  = 1'b0;
    if (CLEAR) begin
      acc_d     = '0;
      cnt_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (P_VALID) begin
      if (cnt_q == CNT_LAST) begin
        push_req  = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
      end else begin
        acc_d     = sum;
        ovf_acc_d = sum_ovf;
        cnt_d     = cnt_q + 1'b1;
      end
    end
  end

  assign pop       = ACC_VALID & ACC_READY;
  assign drop      = push_req & fifo_full & ~pop;
  assign fifo_push = push_req & ~drop;

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      drop_q    <= drop_d;
    end
  end

  dsp_out_fifo2 #(
    .W (ACC_W + 1)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i ({sum_ovf, sum}),
    .full_o      (fifo_full),
    .valid_o     (ACC_VALID),
    .ready_i     (ACC_READY),
    .data_o      ({ACC_OVF, ACC_OUT})
  );

  assign DROP_CNT = drop_q;
  assign BUSY     = (cnt_q != '0);

endmodule
